// File: rtl/c3lib_mstrap_capture.sv
// Capture-and-hold stage for metal-programmable strap tie cells: settle, double-sample,
// publish a registered config word, then allow one-shot overrides via a req/ack handshake.
module c3lib_mstrap_capture #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 16,
  parameter int RETRY_MAX  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             ovrd_req,
  input  logic [WIDTH-1:0] ovrd_data,
  output logic             ovrd_ack,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             cfg_src,
  output logic             cap_err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMP1  = 2'd1;
  localparam logic [1:0] ST_SAMP2  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    retry;
  logic [WIDTH-1:0] s1;
  logic             req_q;
  logic             pend;
  logic             req_edge;
  logic             accept;

  // Handshake: ovrd_req is a level; only its rising edge (or an edge latched
  // before capture finished) is honoured, and ovrd_ack answers with a single
  // cycle pulse in the cycle cfg_out takes ovrd_data.
  assign req_edge = ovrd_req & ~req_q;
  assign accept   = (state == ST_DONE) && (req_edge || pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      retry     <= '0;
      s1        <= '0;
      req_q     <= 1'b0;
      pend      <= 1'b0;
      ovrd_ack  <= 1'b0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      cfg_src   <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      req_q    <= ovrd_req;
      ovrd_ack <= 1'b0;

      case (state)
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            cnt   <= '0;
            state <= ST_SAMP1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMP1: begin
          s1    <= strap_in;
          state <= ST_SAMP2;
        end
        ST_SAMP2: begin
          if (strap_in == s1) begin
            cfg_out   <= strap_in;
            cfg_valid <= 1'b1;
            cfg_src   <= 1'b0;
            cap_err   <= 1'b0;
            state     <= ST_DONE;
          end else if (retry != RW'(RETRY_MAX)) begin
            retry <= retry + 1'b1;
            state <= ST_SETTLE;
          end else begin
            // Out of retries: publish the last sample but flag it as unstable.
            cfg_out   <= strap_in;
            cfg_valid <= 1'b1;
            cfg_src   <= 1'b0;
            cap_err   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        default: begin
        end
      endcase

      // A request edge seen before DONE is remembered and served on the first DONE cycle.
      if (state != ST_DONE) begin
        if (req_edge) pend <= 1'b1;
      end else if (accept) begin
        cfg_out  <= ovrd_data;
        cfg_src  <= 1'b1;
        ovrd_ack <= 1'b1;
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c3lib_mstrap_capture.sv
// Bench for c3lib_mstrap_capture: table of strap capture scenarios plus hand-written
// override, pending-request and asynchronous-reset sequences.
module tb_c3lib_mstrap_capture;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] strap_in;
  logic         ovrd_req;
  logic [W-1:0] ovrd_data;
  logic         ovrd_ack;
  logic [W-1:0] cfg_out;
  logic         cfg_valid;
  logic         cfg_src;
  logic         cap_err;

  c3lib_mstrap_capture #(.WIDTH(W), .SETTLE_CYC(16), .RETRY_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strap_in  (strap_in),
    .ovrd_req  (ovrd_req),
    .ovrd_data (ovrd_data),
    .ovrd_ack  (ovrd_ack),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .cfg_src   (cfg_src),
    .cap_err   (cap_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // capture scoreboard entry: {edge[7:0], cap_err, cfg_src, cfg_out[7:0]}
  logic [17:0]  exp_q[$];
  logic [W-1:0] ovr_q[$];

  typedef struct {
    int           mode;     // 0 constant a, 1 a through edge 17 then b, 2 a on odd edges / b on even
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           exp_edge;
    logic [W-1:0] exp_cfg;
    logic         exp_err;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cfg_out"},   32'(cfg_out),   32'h0);
    chk({tag, "_cfg_valid"}, 32'(cfg_valid), 32'h0);
    chk({tag, "_cfg_src"},   32'(cfg_src),   32'h0);
    chk({tag, "_cap_err"},   32'(cap_err),   32'h0);
    chk({tag, "_ovrd_ack"},  32'(ovrd_ack),  32'h0);
  endtask

  // Leaves the bench at a negedge with rst_n just released: the next posedge is edge 1.
  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    ovrd_req = 1'b0;
    ovrd_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] pattern(input vec_t v, input int n);
    case (v.mode)
      0:       return v.a;
      1:       return (n <= 17) ? v.a : v.b;
      default: return (n % 2 == 1) ? v.a : v.b;
    endcase
  endfunction

  // ---------------- driver: run one capture from edge 1 ----------------
  task automatic run_capture(input vec_t v);
    logic [17:0] e;
    int got_edge;
    got_edge = 0;
    exp_q.push_back({8'(v.exp_edge), v.exp_err, 1'b0, v.exp_cfg});
    for (int n = 1; n <= 100 && got_edge == 0; n++) begin
      strap_in = pattern(v, n);
      @(posedge clk);
      #1;
      if (cfg_valid) got_edge = n;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    if (got_edge == 0) begin
      checks++;
      errors++;
      $display("FAIL cap_timeout: cfg_valid not seen within 100 edges, expected edge %0d", e[17:10]);
    end else begin
      chk("cap_edge",    32'(got_edge),  32'(e[17:10]));
      chk("cap_cfg_out", 32'(cfg_out),   32'(e[7:0]));
      chk("cap_cfg_src", 32'(cfg_src),   32'(e[8]));
      chk("cap_err",     32'(cap_err),   32'(e[9]));
    end
  endtask

  // ---------------- driver: one override in DONE ----------------
  task automatic do_override(input logic [W-1:0] d, input logic exp_err, input int hold);
    int n;
    int extra;
    logic [W-1:0] e;
    ovrd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ovrd_req  = 1'b1;
    ovrd_data = d;
    ovr_q.push_back(d);
    n = 0;
    while (n < 4 && !ovrd_ack) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = ovr_q.pop_front();
    if (!ovrd_ack) begin
      checks++;
      errors++;
      $display("FAIL ovr_timeout: no ovrd_ack within 4 edges, expected cfg_out %0h", e);
    end else begin
      chk("ovr_latency", 32'(n),       32'd1);
      chk("ovr_cfg_out", 32'(cfg_out), 32'(e));
      chk("ovr_cfg_src", 32'(cfg_src), 32'd1);
      chk("ovr_cap_err", 32'(cap_err), 32'(exp_err));
    end
    @(negedge clk);
    ovrd_data = ~d;
    extra = 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (ovrd_ack) extra++;
    end
    chk("ovr_single_ack", 32'(extra),   32'd0);
    chk("ovr_hold_cfg",   32'(cfg_out), 32'(e));
    @(negedge clk);
    ovrd_req = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int early_acks;
    rst_n     = 1'b0;
    strap_in  = '0;
    ovrd_req  = 1'b0;
    ovrd_data = '0;

    vecs[0] = '{mode: 0, a: 8'hA5, b: 8'hA5, exp_edge: 18, exp_cfg: 8'hA5, exp_err: 1'b0};
    vecs[1] = '{mode: 1, a: 8'h3C, b: 8'h3D, exp_edge: 36, exp_cfg: 8'h3D, exp_err: 1'b0};
    vecs[2] = '{mode: 2, a: 8'h00, b: 8'hFF, exp_edge: 72, exp_cfg: 8'hFF, exp_err: 1'b1};

    @(posedge clk);
    #1;
    chk_zero("reset");

    for (int i = 0; i < 3; i++) begin
      apply_reset();
      run_capture(vecs[i]);
      do_override(8'($urandom_range(0, 255)), vecs[i].exp_err, 2);
    end

    // Held request gives one ack; a fresh edge gives a second.
    apply_reset();
    run_capture(vecs[0]);
    do_override(8'h5A, 1'b0, 10);
    do_override(8'h11, 1'b0, 2);

    // Asynchronous reset while DONE with an override applied.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_capture(vecs[0]);

    // Request raised before capture completes is held until DONE.
    apply_reset();
    strap_in   = 8'hA5;
    early_acks = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 5) begin
        ovrd_req  = 1'b1;
        ovrd_data = 8'h77;
      end
      @(posedge clk);
      #1;
      if (n < 19 && ovrd_ack) early_acks++;
      if (n == 17) chk("pend_valid_17", 32'(cfg_valid), 32'd0);
      if (n == 18) begin
        chk("pend_valid_18", 32'(cfg_valid), 32'd1);
        chk("pend_cfg_18",   32'(cfg_out),   32'hA5);
        chk("pend_src_18",   32'(cfg_src),   32'd0);
      end
      if (n == 19) begin
        chk("pend_ack_19", 32'(ovrd_ack), 32'd1);
        chk("pend_cfg_19", 32'(cfg_out),  32'h77);
        chk("pend_src_19", 32'(cfg_src),  32'd1);
      end
      if (n == 20) chk("pend_ack_20", 32'(ovrd_ack), 32'd0);
      @(negedge clk);
    end
    chk("pend_early_acks", 32'(early_acks), 32'd0);
    ovrd_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c3lib_mstrap_capture.md
# c3lib_mstrap_capture

Capture-and-hold stage directly downstream of the metal-programmable tie cells (tie-low/tie-high straps). After reset it waits for the strap nets to settle, samples them twice to confirm stability, and presents a registered configuration word with a valid flag to the rest of the design. After capture, a single-cycle request/acknowledge handshake lets firmware or a test controller override the strapped value without a metal respin.

## Interface
- WIDTH, 8: number of strap bits, from 1 to 32.
- SETTLE_CYC, 16: settle-wait cycles before each sample attempt, at least 1.
- RETRY_MAX, 3: re-settle attempts allowed after a mismatch, at least 0.

- clk  in  1  single clock for all state.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous.
- strap_in  in  WIDTH  strap bits driven by the tie cells. They are quasi-static and not synchronised.
- ovrd_req  in  1  override request, level. Accepted on its rising edge.
- ovrd_data  in  WIDTH  override value, sampled in the cycle the request is accepted.
- ovrd_ack  out  1  one-cycle pulse confirming that the override was applied.
- cfg_out  out  WIDTH  current configuration word.
- cfg_valid  out  1  cfg_out is final. Stays high until reset once set.
- cfg_src  out  1  0 = cfg_out came from the straps, 1 = cfg_out came from an override.
- cap_err  out  1  the straps never sampled stable; cfg_out holds the last sample.

## Operation
- Reset values: FSM = SETTLE, settle counter = 0, retry counter = 0, s1 = 0. All outputs are 0: cfg_out, cfg_valid, cfg_src, cap_err, ovrd_ack. The request edge register is cleared to 0.
- FSM states are SETTLE, SAMP1, SAMP2 and DONE.
- SETTLE:
  - The counter increments each cycle.
  - When the counter reaches SETTLE_CYC-1, it clears to 0 and the FSM goes to SAMP1.
  - Counter width is $clog2(SETTLE_CYC+1).
- SAMP1: s1 <= strap_in, then go to SAMP2.
- SAMP2, match (strap_in == s1): cfg_out <= strap_in, cfg_valid <= 1, cfg_src <= 0, cap_err <= 0, go to DONE.
- SAMP2, mismatch with retry counter < RETRY_MAX: increment the retry counter and go to SETTLE.
- SAMP2, mismatch with retry counter == RETRY_MAX: cfg_out <= strap_in, cfg_valid <= 1, cap_err <= 1, go to DONE.
- DONE is terminal until reset. strap_in is ignored in DONE.
- Override edge detection:
  - req_q registers ovrd_req every cycle in every state.
  - An edge is ovrd_req & ~req_q.
- Override acceptance happens only on an edge while in DONE:
  - cfg_out <= ovrd_data, cfg_src <= 1, ovrd_ack <= 1 for one cycle.
  - cap_err is unchanged.
- Pending override: if ovrd_req is high on the cycle the FSM enters DONE and was not yet accepted, it is accepted in the first DONE cycle.
  - This pending latch is set by any edge seen before DONE and cleared on acceptance.
- Holding ovrd_req high does not re-trigger. A new override needs ovrd_req low for at least one cycle.
- Reset mid-operation: all state returns to reset values immediately, including in DONE with an applied override. Capture restarts from SETTLE.

## Timing
- Counting from the first rising clk edge with rst_n high as edge 1, on a clean capture cfg_valid and cfg_out update at edge SETTLE_CYC+2.
- Each mismatch adds SETTLE_CYC+2 cycles.
- Worst case to cfg_valid is (RETRY_MAX+1)*(SETTLE_CYC+2) edges.
- Override latency, with ovrd_req rising before edge k in DONE:
  - cfg_out, cfg_src and ovrd_ack update at edge k.
  - ovrd_ack drops at edge k+1.
- A pending request reaches DONE on edge d; its ack is at edge d+1.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- WIDTH=8, SETTLE_CYC=16, strap_in=8'hA5 held constant -> cfg_valid rises at edge 18 with cfg_out=A5, cfg_src=0, cap_err=0.
- strap_in=8'h3C in SAMP1, then 8'h3D in SAMP2 once only, then 8'h3D stable -> one retry, cfg_valid at edge 36, cfg_out=3D.
- strap_in toggles between 00 and FF every cycle, RETRY_MAX=3 -> cfg_valid at edge 72 with cap_err=1, cfg_out equal to the SAMP2 sample.
- After capture, ovrd_req rises with ovrd_data=8'h5A and is held high for 10 cycles -> cfg_out=5A, cfg_src=1, exactly one ovrd_ack pulse. Dropping the request and re-raising it with ovrd_data=8'h11 gives a second ack and cfg_out=11.
- ovrd_req raised at edge 5 with ovrd_data=8'h77 and held -> no ack before DONE. Ack at edge 19, cfg_out=77 from edge 19.
- rst_n pulsed low while in DONE with an override applied -> all outputs are 0 asynchronously, and recapture finishes at edge 18 after release.
